// File: rtl/satagtx_rst_seq_pkg.sv
// Shared constants for the SATA GTX reset sequencer: state encodings and counter width.
// The link layer decodes seq_state with these same constants.
package satagtx_rst_seq_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] S_GTXRST    = 3'd0;
  localparam logic [2:0] S_WAIT_PLL  = 3'd1;
  localparam logic [2:0] S_WAIT_DCM  = 3'd2;
  localparam logic [2:0] S_USRRST    = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

endpackage

// File: rtl/satagtx_sync2.sv
// 1-bit two-flop synchronizer for GTX status inputs arriving asynchronously to clk.
module satagtx_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic r_meta;
  (* ASYNC_REG = "TRUE", keep = "true" *) logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/satagtx_rst_seq.sv
// GTX bring-up/reset sequencer: pulses the tile reset, waits for PLL/DCM lock and
// reset-done, then releases the fabric reset; retries on timeout or lock loss.
module satagtx_rst_seq
  import satagtx_rst_seq_pkg::*;
#(
  parameter string       C_FAMILY        = "virtex5",
  parameter int unsigned C_GTXRST_CYCLES = 8,
  parameter int unsigned C_USRRST_CYCLES = 16,
  parameter int unsigned C_LOCK_TIMEOUT  = 65535,
  parameter int unsigned C_MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tile0_plllkdet,
  input  logic       refclkout_dcm0_locked,
  input  logic       tile0_txresetdone,
  input  logic       tile0_rxresetdone,
  output logic       gtx_reset,
  output logic       usr_rst,
  output logic       phy_ready,
  output logic       phy_err,
  output logic [3:0] retry_cnt,
  output logic [2:0] seq_state
);

  if (!(C_FAMILY == "virtex5" || C_FAMILY == "spartan6")) begin : g_bad_family
    $error("satagtx_rst_seq: C_FAMILY must be virtex5 or spartan6");
  end

  localparam logic [CNT_W-1:0] L_GTX_LAST = CNT_W'(C_GTXRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_USR_LAST = CNT_W'(C_USRRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(C_LOCK_TIMEOUT - 1);
  localparam logic [3:0]       L_RTY_LAST = 4'(C_MAX_RETRY - 1);

  logic w_plllk_s, w_dcmlk_s, w_txdone_s, w_rxdone_s;

  satagtx_sync2 u_sync_pll (.i_clk(clk), .i_rst(rst), .i_d(tile0_plllkdet),        .o_q(w_plllk_s));
  satagtx_sync2 u_sync_dcm (.i_clk(clk), .i_rst(rst), .i_d(refclkout_dcm0_locked), .o_q(w_dcmlk_s));
  satagtx_sync2 u_sync_tx  (.i_clk(clk), .i_rst(rst), .i_d(tile0_txresetdone),     .o_q(w_txdone_s));
  satagtx_sync2 u_sync_rx  (.i_clk(clk), .i_rst(rst), .i_d(tile0_rxresetdone),     .o_q(w_rxdone_s));

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic             r_gtx, r_usr, r_rdy, r_err;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_retry_nxt;
  logic             w_fail;
  logic             w_lockloss;
  logic             w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_fail      = 1'b0;
    w_lockloss  = !w_plllk_s || !w_dcmlk_s;
    w_timeout   = (r_cnt == L_TO_LAST);

    // Lock loss beats the exit condition; the exit condition beats the timeout.
    case (r_state)
      S_GTXRST:    if (r_cnt == L_GTX_LAST) w_state_nxt = S_WAIT_PLL;
      S_WAIT_PLL:  if (w_plllk_s) w_state_nxt = S_WAIT_DCM;
                   else if (w_timeout) w_fail = 1'b1;
      S_WAIT_DCM:  if (!w_plllk_s) w_fail = 1'b1;
                   else if (w_dcmlk_s) w_state_nxt = S_USRRST;
                   else if (w_timeout) w_fail = 1'b1;
      S_USRRST:    if (w_lockloss) w_fail = 1'b1;
                   else if (r_cnt == L_USR_LAST) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (w_lockloss) w_fail = 1'b1;
                   else if (w_txdone_s && w_rxdone_s) w_state_nxt = S_READY;
                   else if (w_timeout) w_fail = 1'b1;
      S_READY:     if (w_lockloss) w_state_nxt = S_GTXRST;
      S_FAIL:      w_state_nxt = S_FAIL;
      default:     w_state_nxt = S_GTXRST;
    endcase

    if (w_fail) begin
      w_state_nxt = (r_retry == L_RTY_LAST) ? S_FAIL : S_GTXRST;
      if (r_retry != 4'hF) w_retry_nxt = r_retry + 4'd1;
    end

    if (w_state_nxt == S_READY) w_retry_nxt = '0;

    if (w_state_nxt != r_state || w_state_nxt == S_READY || w_state_nxt == S_FAIL)
      w_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GTXRST;
      r_cnt   <= '0;
      r_retry <= '0;
      r_gtx   <= 1'b1;
      r_usr   <= 1'b1;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_gtx   <= (w_state_nxt == S_GTXRST);
      r_usr   <= (w_state_nxt != S_READY);
      r_rdy   <= (w_state_nxt == S_READY);
      r_err   <= (w_state_nxt == S_FAIL);
    end
  end

  assign gtx_reset = r_gtx;
  assign usr_rst   = r_usr;
  assign phy_ready = r_rdy;
  assign phy_err   = r_err;
  assign retry_cnt = r_retry;
  assign seq_state = r_state;

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Scoreboard bench for satagtx_rst_seq: stimulus queues expected state transitions
// (state, retry count, cycle); a monitor pops and checks each one as it happens.
module tb_satagtx_rst_seq;
  import satagtx_rst_seq_pkg::*;

  localparam int GTX = 8;
  localparam int USR = 16;
  localparam int TO  = 100;
  localparam int MR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll = 1'b0, dcm = 1'b0, txd = 1'b0, rxd = 1'b0;
  logic       gtx_reset, usr_rst, phy_ready, phy_err;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;

  satagtx_rst_seq #(
    .C_FAMILY        ("virtex5"),
    .C_GTXRST_CYCLES (GTX),
    .C_USRRST_CYCLES (USR),
    .C_LOCK_TIMEOUT  (TO),
    .C_MAX_RETRY     (MR)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .tile0_plllkdet        (pll),
    .refclkout_dcm0_locked (dcm),
    .tile0_txresetdone     (txd),
    .tile0_rxresetdone     (rxd),
    .gtx_reset             (gtx_reset),
    .usr_rst               (usr_rst),
    .phy_ready             (phy_ready),
    .phy_err               (phy_err),
    .retry_cnt             (retry_cnt),
    .seq_state             (seq_state)
  );

  typedef struct {
    logic [2:0] st;
    logic [3:0] retry;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] st, input int r, input int c);
    exp_t e;
    e.st    = st;
    e.retry = 4'(r);
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seq_state"}, int'(seq_state), int'(S_GTXRST));
    chk({tag, "_gtx_reset"}, int'(gtx_reset), 1);
    chk({tag, "_usr_rst"},   int'(usr_rst),   1);
    chk({tag, "_phy_ready"}, int'(phy_ready), 0);
    chk({tag, "_phy_err"},   int'(phy_err),   0);
    chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
  endtask

  // Monitor: every change of seq_state must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && seq_state != prev_st) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_transition: got state %0d from %0d, expected none (cycle %0d)",
                 seq_state, prev_st, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("trans_state",     int'(seq_state), int'(mon_e.st));
        chk("trans_cycle",     cyc,             mon_e.cyc);
        chk("trans_retry_cnt", int'(retry_cnt), int'(mon_e.retry));
        chk("trans_gtx_reset", int'(gtx_reset), int'(mon_e.st == S_GTXRST));
        chk("trans_usr_rst",   int'(usr_rst),   int'(mon_e.st != S_READY));
        chk("trans_phy_ready", int'(phy_ready), int'(mon_e.st == S_READY));
        chk("trans_phy_err",   int'(phy_err),   int'(mon_e.st == S_FAIL));
      end
    end
    prev_st = seq_state;
  end

  initial begin
    int r;
    int a;

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    mon_en = 1'b1;

    // Nominal bring-up.
    r = cyc;
    rst = 1'b0;
    push(S_WAIT_PLL, 0, r + 8);
    go_to(r + 20); pll = 1'b1;
    push(S_WAIT_DCM, 0, r + 23);
    go_to(r + 30); dcm = 1'b1;
    push(S_USRRST,    0, r + 33);
    push(S_WAIT_DONE, 0, r + 49);
    push(S_READY,     0, r + 50);
    go_to(r + 35); txd = 1'b1; rxd = 1'b1;
    go_to(r + 55);
    chk("nom_phy_ready", int'(phy_ready), 1);
    chk("nom_usr_rst",   int'(usr_rst),   0);
    chk("nom_retry_cnt", int'(retry_cnt), 0);

    // One-cycle DCM lock drop while READY: uncounted restart.
    go_to(r + 60); dcm = 1'b0;
    push(S_GTXRST, 0, r + 63);
    go_to(r + 61); dcm = 1'b1;
    push(S_WAIT_PLL,  0, r + 71);
    push(S_WAIT_DCM,  0, r + 72);
    push(S_USRRST,    0, r + 73);
    push(S_WAIT_DONE, 0, r + 89);
    push(S_READY,     0, r + 90);
    go_to(r + 66);
    chk("ll_phy_ready", int'(phy_ready), 0);
    chk("ll_gtx_reset", int'(gtx_reset), 1);
    chk("ll_retry_cnt", int'(retry_cnt), 0);
    go_to(r + 95);
    chk("ll_ready_again", int'(phy_ready), 1);

    // Reset from READY, then reset again at cycle 4 of the GTXRST pulse.
    a = cyc;
    rst = 1'b1; txd = 1'b0; rxd = 1'b0;
    push(S_GTXRST, 0, a + 1);
    go_to(a + 2); rst = 1'b0;
    r = cyc;
    go_to(r + 4); rst = 1'b1;
    go_to(r + 5);
    chk_reset_vals("midpulse");
    rst = 1'b0;
    r = cyc;

    // First attempt times out in WAIT_DONE, second attempt succeeds.
    push(S_WAIT_PLL,  0, r + 8);
    push(S_WAIT_DCM,  0, r + 9);
    push(S_USRRST,    0, r + 10);
    push(S_WAIT_DONE, 0, r + 26);
    push(S_GTXRST,    1, r + 126);
    go_to(r + 130); txd = 1'b1; rxd = 1'b1;
    push(S_WAIT_PLL,  1, r + 134);
    push(S_WAIT_DCM,  1, r + 135);
    push(S_USRRST,    1, r + 136);
    push(S_WAIT_DONE, 1, r + 152);
    push(S_READY,     0, r + 153);
    go_to(r + 140);
    chk("to_retry_second_attempt", int'(retry_cnt), 1);
    go_to(r + 158);
    chk("to_phy_ready", int'(phy_ready), 1);
    chk("to_retry_ready", int'(retry_cnt), 0);

    // DCM lock arrives on the exact WAIT_DCM timeout cycle: exit wins.
    a = cyc;
    rst = 1'b1; dcm = 1'b0;
    push(S_GTXRST, 0, a + 1);
    go_to(a + 2); rst = 1'b0;
    r = cyc;
    push(S_WAIT_PLL,  0, r + 8);
    push(S_WAIT_DCM,  0, r + 9);
    push(S_USRRST,    0, r + 109);
    push(S_WAIT_DONE, 0, r + 125);
    push(S_READY,     0, r + 126);
    go_to(r + 106); dcm = 1'b1;
    go_to(r + 130);
    chk("sim_retry_cnt", int'(retry_cnt), 0);
    chk("sim_phy_ready", int'(phy_ready), 1);

    // PLL never locks: three attempts, then absorbing FAIL.
    a = cyc;
    rst = 1'b1; pll = 1'b0; dcm = 1'b0;
    push(S_GTXRST, 0, a + 1);
    go_to(a + 2); rst = 1'b0;
    r = cyc;
    push(S_WAIT_PLL, 0, r + 8);
    push(S_GTXRST,   1, r + 108);
    push(S_WAIT_PLL, 1, r + 116);
    push(S_GTXRST,   2, r + 216);
    push(S_WAIT_PLL, 2, r + 224);
    push(S_FAIL,     3, r + 324);
    go_to(r + 330);
    chk("fail_seq_state", int'(seq_state), int'(S_FAIL));
    chk("fail_phy_err",   int'(phy_err),   1);
    chk("fail_gtx_reset", int'(gtx_reset), 0);
    chk("fail_retry_cnt", int'(retry_cnt), 3);
    chk("fail_phy_ready", int'(phy_ready), 0);
    go_to(r + 360);
    chk("fail_absorb_state", int'(seq_state), int'(S_FAIL));
    chk("fail_absorb_gtx",   int'(gtx_reset), 0);

    // Reset out of FAIL clears the sticky error.
    a = cyc;
    rst = 1'b1;
    push(S_GTXRST, 0, a + 1);
    go_to(a + 1);
    chk_reset_vals("from_fail");
    rst = 1'b0;
    go_to(cyc + 3);
    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
